// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding, IF/ID controls,
// bubble word and instruction field positions.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_t;

  localparam int          INSTR_W   = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RS_MSB     = 11;
  localparam int RS_LSB     = 8;
  localparam int RT_MSB     = 7;
  localparam int RT_LSB     = 4;

  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [3:0] instr_rs(input logic [INSTR_W-1:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [3:0] instr_rt(input logic [INSTR_W-1:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: loads a fetched instruction, holds it during a
// stall, or replaces it with a bubble.
module ifid_register
  import fetch_stage_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [15:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  ifid_op_t          op,
  input  logic [15:0]       instr_d,
  input  logic [ADDR_W-1:0] pc_plus1_d,
  output logic              valid,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] pc_plus1
);

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc_plus1 <= '0;
    end else begin
      case (op)
        IFID_LOAD: begin
          valid    <= 1'b1;
          instr    <= instr_d;
          pc_plus1 <= pc_plus1_d;
        end
        IFID_BUBBLE: begin
          valid    <= 1'b0;
          instr    <= NOP_INSTR;
          pc_plus1 <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake with
// stall hold buffer and branch discard, feeding the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]       NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              ifid_write,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  output logic              ifid_valid,
  output logic [15:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc_plus1,
  output logic [3:0]        ifid_rs,
  output logic [3:0]        ifid_rt
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] stale_addr;
  logic [15:0]       hold_instr;
  logic [ADDR_W-1:0] hold_pc_plus1;
  logic              accept;
  logic              advance;

  ifid_op_t          ifid_op;
  logic [15:0]       ifid_instr_d;
  logic [ADDR_W-1:0] ifid_pc_plus1_d;

  assign pc_plus1  = pc + 1'b1;
  assign accept    = imem_req && imem_ready;
  assign advance   = pc_write && ifid_write;
  // A discarded request keeps presenting the address it was issued with.
  assign imem_addr = (state == DISCARD) ? stale_addr : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      imem_req      <= 1'b0;
      stale_addr    <= '0;
      hold_instr    <= NOP_INSTR;
      hold_pc_plus1 <= '0;
    end else if (branch_taken) begin
      pc            <= branch_target;
      imem_req      <= 1'b1;
      hold_instr    <= NOP_INSTR;
      hold_pc_plus1 <= '0;
      if (imem_req && !accept) begin
        state      <= DISCARD;
        stale_addr <= imem_addr;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          imem_req <= 1'b1;
          if (accept && !advance) begin
            hold_instr    <= imem_rdata;
            hold_pc_plus1 <= pc_plus1;
            state         <= HOLD;
            imem_req      <= 1'b0;
          end else if (accept) begin
            pc <= pc_plus1;
          end
        end
        HOLD: begin
          if (advance) begin
            pc       <= pc_plus1;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        DISCARD: begin
          if (accept) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // infer a latch.
  always_comb begin
    ifid_op         = IFID_HOLD;
    ifid_instr_d    = imem_rdata;
    ifid_pc_plus1_d = pc_plus1;
    if (branch_taken) begin
      ifid_op = IFID_BUBBLE;
    end else begin
      case (state)
        FETCH: begin
          if (accept && advance) ifid_op = IFID_LOAD;
          else if (ifid_write)   ifid_op = IFID_BUBBLE;
        end
        HOLD: begin
          if (advance) begin
            ifid_op         = IFID_LOAD;
            ifid_instr_d    = hold_instr;
            ifid_pc_plus1_d = hold_pc_plus1;
          end else if (ifid_write) begin
            ifid_op = IFID_BUBBLE;
          end
        end
        default: begin
          if (ifid_write) ifid_op = IFID_BUBBLE;
        end
      endcase
    end
  end

  ifid_register #(
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .op         (ifid_op),
    .instr_d    (ifid_instr_d),
    .pc_plus1_d (ifid_pc_plus1_d),
    .valid      (ifid_valid),
    .instr      (ifid_instr),
    .pc_plus1   (ifid_pc_plus1)
  );

  assign ifid_rs = instr_rs(ifid_instr);
  assign ifid_rt = instr_rt(ifid_instr);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural fetch model checked every
// cycle, plus hand-computed expectations along the scenario.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        ifid_write;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus1;
  logic [3:0]  ifid_rs;
  logic [3:0]  ifid_rt;

  int n_vec = 0;
  int n_mis = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address a is a + 16'h1000.
  assign imem_rdata = imem_addr + 16'h1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage must present, tracked as the
  // outstanding request, whether its data is to be dropped, and a parked word.
  logic        m_live = 1'b0;
  logic        m_req, m_drop, m_park;
  logic [15:0] m_pc, m_addr, m_park_instr, m_park_pc1;
  logic        m_v;
  logic [15:0] m_i, m_p1;

  always @(posedge clk) begin
    logic        acc;
    logic [15:0] word;
    if (rst) begin
      m_live = 1'b1;
      m_req = 1'b0; m_drop = 1'b0; m_park = 1'b0;
      m_pc = 16'h0000; m_addr = 16'h0000;
      m_park_instr = 16'h0000; m_park_pc1 = 16'h0000;
      m_v = 1'b0; m_i = 16'h0000; m_p1 = 16'h0000;
    end else begin
      acc  = m_req && imem_ready;
      word = m_addr + 16'h1000;
      if (branch_taken) begin
        m_v = 1'b0; m_i = 16'h0000;
        m_park = 1'b0;
        m_drop = m_req && !acc;
        m_pc   = branch_target;
        m_req  = 1'b1;
        if (!m_drop) m_addr = branch_target;
      end else if (m_drop) begin
        if (ifid_write) begin m_v = 1'b0; m_i = 16'h0000; end
        if (acc) begin m_drop = 1'b0; m_addr = m_pc; end
      end else if (m_park) begin
        if (pc_write && ifid_write) begin
          m_v = 1'b1; m_i = m_park_instr; m_p1 = m_park_pc1;
          m_pc = m_pc + 16'd1;
          m_park = 1'b0; m_req = 1'b1; m_addr = m_pc;
        end else if (ifid_write) begin
          m_v = 1'b0; m_i = 16'h0000;
        end
      end else if (acc) begin
        if (pc_write && ifid_write) begin
          m_v = 1'b1; m_i = word; m_p1 = m_addr + 16'd1;
          m_pc = m_pc + 16'd1; m_addr = m_pc;
        end else begin
          m_park_instr = word; m_park_pc1 = m_addr + 16'd1;
          m_park = 1'b1; m_req = 1'b0;
          if (ifid_write) begin m_v = 1'b0; m_i = 16'h0000; end
        end
      end else begin
        if (ifid_write) begin m_v = 1'b0; m_i = 16'h0000; end
        m_req = 1'b1; m_addr = m_pc;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_req", 32'(imem_req), 32'(m_req));
      if (m_req) check("model_addr", 32'(imem_addr), 32'(m_addr));
      check("model_valid", 32'(ifid_valid), 32'(m_v));
      check("model_instr", 32'(ifid_instr), 32'(m_i));
      if (m_v) check("model_pc1", 32'(ifid_pc_plus1), 32'(m_p1));
      check("model_rs", 32'(ifid_rs), 32'(m_i[11:8]));
      check("model_rt", 32'(ifid_rt), 32'(m_i[7:4]));
    end
  end

  // Apply one cycle of inputs, then return at the following falling edge.
  task automatic cyc(input logic pw, input logic iw, input logic rdy,
                     input logic br, input logic [15:0] tgt);
    pc_write = pw; ifid_write = iw; imem_ready = rdy;
    branch_taken = br; branch_target = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] tbl;
    logic [3:0]  v;
    rst = 1'b1; pc_write = 1'b0; ifid_write = 1'b0; imem_ready = 1'b0;
    branch_taken = 1'b0; branch_target = 16'h0000;
    @(negedge clk);
    cyc(0, 0, 0, 0, 16'h0);
    cyc(0, 0, 0, 0, 16'h0);
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_valid", 32'(ifid_valid), 32'd0);
    check("rst_instr", 32'(ifid_instr), 32'h0000);
    check("rst_pc1",   32'(ifid_pc_plus1), 32'h0000);

    // Zero-wait streaming from address 0.
    rst = 1'b0;
    cyc(1, 1, 1, 0, 16'h0);
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'h0000);
    cyc(1, 1, 1, 0, 16'h0);
    check("stream_instr0", 32'(ifid_instr), 32'h1000);
    check("stream_valid0", 32'(ifid_valid), 32'd1);
    check("stream_pc1_0",  32'(ifid_pc_plus1), 32'h0001);
    check("stream_addr1",  32'(imem_addr), 32'h0001);
    cyc(1, 1, 1, 0, 16'h0);
    cyc(1, 1, 1, 0, 16'h0);
    check("stream_instr2", 32'(ifid_instr), 32'h1002);
    check("stream_addr3",  32'(imem_addr), 32'h0003);

    // One-cycle hazard stall while IF/ID holds 1002.
    cyc(0, 0, 1, 0, 16'h0);
    check("stall_hold", 32'(ifid_instr), 32'h1002);
    check("stall_req",  32'(imem_req), 32'd0);
    cyc(1, 1, 1, 0, 16'h0);
    check("stall_next", 32'(ifid_instr), 32'h1003);
    check("stall_addr", 32'(imem_addr), 32'h0004);

    // Three-cycle memory wait.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 16'h0);
      check("wait_valid", 32'(ifid_valid), 32'd0);
      check("wait_instr", 32'(ifid_instr), 32'h0000);
      check("wait_addr",  32'(imem_addr), 32'h0004);
    end
    cyc(1, 1, 1, 0, 16'h0);
    check("wait_done", 32'(ifid_instr), 32'h1004);
    check("wait_next_addr", 32'(imem_addr), 32'h0005);

    // Branch while the request to 5 is pending; ready two cycles later.
    cyc(1, 1, 0, 1, 16'h0040);
    check("br_valid", 32'(ifid_valid), 32'd0);
    check("br_stale_addr", 32'(imem_addr), 32'h0005);
    cyc(1, 1, 0, 0, 16'h0);
    check("br_stale_hold", 32'(imem_addr), 32'h0005);
    cyc(1, 1, 1, 0, 16'h0);
    check("br_dropped", 32'(ifid_valid), 32'd0);
    check("br_target_addr", 32'(imem_addr), 32'h0040);
    cyc(1, 1, 1, 0, 16'h0);
    check("br_target_instr", 32'(ifid_instr), 32'h1040);
    check("br_rs", 32'(ifid_rs), 32'h0);
    check("br_rt", 32'(ifid_rt), 32'h4);

    // Branch together with a stall while a fetched word is parked.
    cyc(0, 0, 1, 0, 16'h0);
    check("park_hold", 32'(ifid_instr), 32'h1040);
    cyc(0, 0, 0, 1, 16'h0040);
    check("brstall_valid", 32'(ifid_valid), 32'd0);
    check("brstall_addr",  32'(imem_addr), 32'h0040);
    cyc(1, 1, 1, 0, 16'h0);
    check("brstall_refetch", 32'(ifid_instr), 32'h1040);

    // Wrap from 16'hFFFF to 0.
    cyc(1, 1, 1, 1, 16'hFFFF);
    check("wrap_addr_ffff", 32'(imem_addr), 32'hFFFF);
    cyc(1, 1, 1, 0, 16'h0);
    check("wrap_instr", 32'(ifid_instr), 32'h0FFF);
    check("wrap_pc1",   32'(ifid_pc_plus1), 32'h0000);
    check("wrap_addr0", 32'(imem_addr), 32'h0000);
    check("wrap_rs",    32'(ifid_rs), 32'hF);

    // Reset while parked in the hold state.
    cyc(0, 0, 1, 0, 16'h0);
    rst = 1'b1;
    cyc(1, 1, 1, 0, 16'h0);
    check("rst2_req",   32'(imem_req), 32'd0);
    check("rst2_valid", 32'(ifid_valid), 32'd0);
    check("rst2_instr", 32'(ifid_instr), 32'h0000);
    check("rst2_pc1",   32'(ifid_pc_plus1), 32'h0000);
    rst = 1'b0;

    // Mixed stall/wait/branch vectors {pc_write, ifid_write, ready, branch}.
    tbl = 64'hEE2E_CCE6_AEDC_E3EE;
    for (int i = 0; i < 16; i++) begin
      v = tbl[4*i +: 4];
      cyc(v[3], v[2], v[1], v[0], 16'h0100 + 16'(i));
    end
    cyc(1, 1, 1, 0, 16'h0);
    cyc(1, 1, 1, 0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
